ntt_bram_streamer: RTL and testbench

Load/drain controller for the 18-bit × 2048 dual-port coefficient BRAM in the NTT datapath. It fills the BRAM from an upstream valid/ready stream through the write port. On `start` it drains the stored polynomial through the read port into a downstream valid/ready stream, optionally in bit-reversed order. It hides the BRAM's one-cycle registered-address read latency behind a 2-entry output skid buffer, so full backpressure is supported at one word per cycle.

---
 rtl/ntt_bram_streamer_pkg.sv | 22 ++
 rtl/ntt_bram_streamer_skid_fifo2.sv | 43 ++++
 rtl/ntt_bram_streamer.sv | 124 ++++++++++++
 tb/tb_ntt_bram_streamer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_bram_streamer_pkg.sv
// Shared NTT definitions: controller state encoding, default BRAM geometry and
// the address bit-reverse used by both the streamer and the butterfly address generators.
package ntt_bram_streamer_pkg;

    localparam int unsigned NttDw = 18;
    localparam int unsigned NttAw = 11;
    localparam int unsigned AwMax = 16;

    typedef enum logic [1:0] {
        StLoad,
        StHold,
        StDrain
    } ntt_state_e;

    // Reverse the low w bits of a; bits above w come back as zero.
    function automatic logic [AwMax-1:0] bitrev(input logic [AwMax-1:0] a, input int unsigned w);
        logic [AwMax-1:0] r;
        r = {<<{a}};
        return r >> (AwMax - w);
    endfunction

endpackage

// File: rtl/ntt_bram_streamer_skid_fifo2.sv
// Two-entry FIFO that absorbs the words already in flight from the BRAM when
// the downstream stalls. Simultaneous push and pop are both honoured.
module skid_fifo2 #(
    parameter int unsigned DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          do_pop;

    assign do_pop  = pop_i & (count_q != 2'd0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ntt_bram_streamer.sv
// Load/drain controller for the NTT coefficient BRAM: fills it from a stream, then
// drains it (optionally bit-reversed) with the read latency hidden by a skid FIFO.
module ntt_bram_streamer
    import ntt_bram_streamer_pkg::*;
#(
    parameter int unsigned DW     = NttDw,
    parameter int unsigned AW     = NttAw,
    parameter int unsigned LEN    = 2048,
    parameter int unsigned BITREV = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          start,
    output logic          full,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          bram_wr_en,
    output logic [AW-1:0] bram_wr_addr,
    output logic [DW-1:0] bram_wr_din,
    output logic [AW-1:0] bram_rd_addr,
    input  logic [DW-1:0] bram_rd_dout
);

    if (LEN < 1 || LEN > (1 << AW)) begin : g_bad_len
        $error("ntt_bram_streamer: LEN must be in 1..2**AW");
    end
    if (BITREV != 0 && LEN != (1 << AW)) begin : g_bad_bitrev
        $error("ntt_bram_streamer: BITREV requires LEN == 2**AW");
    end
    if (AW > AwMax) begin : g_bad_aw
        $error("ntt_bram_streamer: AW exceeds AwMax");
    end

    localparam logic [AW:0] LenW   = (AW + 1)'(LEN);
    localparam logic [AW:0] LastW  = (AW + 1)'(LEN - 1);
    localparam logic [AW:0] CntOne = {{AW{1'b0}}, 1'b1};

    ntt_state_e    state_q;
    logic [AW:0]   wcnt_q;
    logic [AW:0]   rcnt_q;
    logic [AW:0]   ocnt_q;
    logic          inflight_q;
    logic [1:0]    fifo_count;
    logic [DW-1:0] fifo_dout;
    logic          pop;
    logic          issue;
    logic [2:0]    occ;

    assign in_ready     = (state_q == StLoad);
    assign full         = (state_q == StHold);
    assign bram_wr_en   = in_ready & in_valid;
    assign bram_wr_addr = wcnt_q[AW-1:0];
    assign bram_wr_din  = in_data;

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_dout;
    assign out_last  = out_valid & (ocnt_q == LastW);
    assign pop       = out_valid & out_ready;

    // Occupancy the FIFO will have after this cycle's pop and the pending push;
    // issuing only when it is at most 1 guarantees room for the new read.
    assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == StDrain) && (rcnt_q < LenW) && (occ <= 3'd1);

    assign bram_rd_addr = (BITREV != 0) ? AW'(bitrev(AwMax'(rcnt_q[AW-1:0]), AW))
                                        : rcnt_q[AW-1:0];

    skid_fifo2 #(
        .DW(DW)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (inflight_q),
        .din_i  (bram_rd_dout),
        .pop_i  (pop),
        .dout_o (fifo_dout),
        .count_o(fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoad;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            ocnt_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        if (wcnt_q == LastW) begin
                            state_q <= StHold;
                            wcnt_q  <= '0;
                        end else begin
                            wcnt_q <= wcnt_q + CntOne;
                        end
                    end
                end
                StHold: begin
                    if (start) begin
                        state_q <= StDrain;
                        rcnt_q  <= '0;
                        ocnt_q  <= '0;
                    end
                end
                StDrain: begin
                    if (issue) rcnt_q <= rcnt_q + CntOne;
                    if (pop) begin
                        ocnt_q <= ocnt_q + CntOne;
                        if (ocnt_q == LastW) state_q <= StLoad;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_bram_streamer.sv
// Bench for ntt_bram_streamer: natural, bit-reversed and LEN=5 builds, each with a
// behavioural BRAM, checked against a model of the loaded polynomial.
module tb_ntt_bram_streamer;

    logic        clk;
    logic        rst          [3];
    logic        in_valid     [3];
    logic        in_ready     [3];
    logic [17:0] in_data      [3];
    logic        start        [3];
    logic        full         [3];
    logic        out_valid    [3];
    logic        out_ready    [3];
    logic [17:0] out_data     [3];
    logic        out_last     [3];
    logic        bram_wr_en   [3];
    logic [10:0] bram_wr_addr [3];
    logic [17:0] bram_wr_din  [3];
    logic [10:0] bram_rd_addr [3];

    logic [17:0] loaded [3][2048];
    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: natural order, 1: bit-reversed, 2: LEN=5.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [17:0] mem [2048];
        logic [17:0] rd_dout;

        ntt_bram_streamer #(
            .DW    (18),
            .AW    (11),
            .LEN   ((g == 2) ? 5 : 2048),
            .BITREV((g == 1) ? 1 : 0)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .in_data     (in_data[g]),
            .start       (start[g]),
            .full        (full[g]),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready[g]),
            .out_data    (out_data[g]),
            .out_last    (out_last[g]),
            .bram_wr_en  (bram_wr_en[g]),
            .bram_wr_addr(bram_wr_addr[g]),
            .bram_wr_din (bram_wr_din[g]),
            .bram_rd_addr(bram_rd_addr[g]),
            .bram_rd_dout(rd_dout)
        );

        always @(posedge clk) begin
            if (bram_wr_en[g]) mem[bram_wr_addr[g]] <= bram_wr_din[g];
            rd_dout <= mem[bram_rd_addr[g]];
        end
    end

    function automatic int rev11(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 11; i++) begin
            r = (r << 1) | (k & 1);
            k = k >> 1;
        end
        return r;
    endfunction

    task automatic load_poly(input int d, input int n, input bit idx_data, input int gap_pct,
                             input bit poke_start);
        int got;
        int cyc;
        logic v;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 8 * n + 100) begin
            v = ($urandom_range(99) >= gap_pct);
            in_valid[d] = v;
            in_data[d]  = idx_data ? 18'(got) : 18'($urandom);
            start[d]    = poke_start && (got == n / 2);
            #1;
            total++;
            if (bram_wr_en[d] !== v || (v && bram_wr_addr[d] !== 11'(got)) || full[d] !== 1'b0) begin
                bad++;
                $display("FAIL load_write d=%0d word=%0d got wr_en=%0b addr=%0d full=%0b want wr_en=%0b addr=%0d full=0",
                         d, got, bram_wr_en[d], bram_wr_addr[d], full[d], v, got);
            end
            if (v && in_ready[d]) begin
                loaded[d][got] = in_data[d];
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid[d] = 1'b0;
        start[d]    = 1'b0;
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL load_timeout d=%0d got=%0d want=%0d", d, got, n);
        end
        total++;
        if (full[d] !== 1'b1 || in_ready[d] !== 1'b0) begin
            bad++;
            $display("FAIL full_after_load d=%0d got full=%0b in_ready=%0b want full=1 in_ready=0",
                     d, full[d], in_ready[d]);
        end
    endtask

    task automatic drain(input int d, input int len, input bit rev, input int ready_pct,
                         input bit timing, input bit poke, input int abort_after);
        int pops;
        int c;
        int first_c;
        bit prev_stall;
        logic [17:0] prev_data;
        logic [17:0] exp;
        pops       = 0;
        first_c    = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
        out_ready[d] = 1'b1;
        start[d]     = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        c = 1;
        if (timing) begin
            total++;
            if (bram_rd_addr[d] !== 11'd0) begin
                bad++;
                $display("FAIL first_rd_addr d=%0d got=%0d want=0", d, bram_rd_addr[d]);
            end
        end
        while (pops < len && (abort_after < 0 || pops < abort_after) && c < 4 * len + 50) begin
            out_ready[d] = ($urandom_range(99) < ready_pct);
            start[d]     = poke && (c == 20);
            #1;
            if (prev_stall) begin
                total++;
                if (out_valid[d] !== 1'b1 || out_data[d] !== prev_data) begin
                    bad++;
                    $display("FAIL stall_hold d=%0d cyc=%0d got valid=%0b data=%0h want valid=1 data=%0h",
                             d, c, out_valid[d], out_data[d], prev_data);
                end
            end
            if (timing && c < 3) begin
                total++;
                if (out_valid[d] !== 1'b0) begin
                    bad++;
                    $display("FAIL early_valid d=%0d cyc=%0d got=%0b want=0", d, c, out_valid[d]);
                end
            end
            if (out_valid[d] && out_ready[d]) begin
                if (first_c < 0) first_c = c;
                exp = loaded[d][rev ? rev11(pops) : pops];
                total++;
                if (out_data[d] !== exp) begin
                    bad++;
                    $display("FAIL out_data d=%0d k=%0d got=%0h want=%0h", d, pops, out_data[d], exp);
                end
                total++;
                if (out_last[d] !== (pops == len - 1)) begin
                    bad++;
                    $display("FAIL out_last d=%0d k=%0d got=%0b want=%0b", d, pops, out_last[d],
                             (pops == len - 1));
                end
                pops++;
            end
            prev_stall = out_valid[d] && !out_ready[d];
            prev_data  = out_data[d];
            @(posedge clk);
            #1;
            c++;
        end
        start[d] = 1'b0;
        if (abort_after >= 0) begin
            total++;
            if (pops != abort_after) begin
                bad++;
                $display("FAIL abort_count d=%0d got=%0d want=%0d", d, pops, abort_after);
            end
            return;
        end
        total++;
        if (pops != len) begin
            bad++;
            $display("FAIL drain_timeout d=%0d got=%0d want=%0d", d, pops, len);
        end
        if (timing) begin
            total++;
            if (first_c != 3 || c - 1 != len + 2) begin
                bad++;
                $display("FAIL drain_timing d=%0d got first=%0d last=%0d want first=3 last=%0d",
                         d, first_c, c - 1, len + 2);
            end
        end
        total++;
        if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || full[d] !== 1'b0) begin
            bad++;
            $display("FAIL turnaround d=%0d got in_ready=%0b out_valid=%0b full=%0b want 1 0 0",
                     d, in_ready[d], out_valid[d], full[d]);
        end
    endtask

    task automatic hold_check(input int d);
        for (int i = 0; i < 3; i++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 18'($urandom);
            #1;
            total++;
            if (in_ready[d] !== 1'b0 || bram_wr_en[d] !== 1'b0 || full[d] !== 1'b1) begin
                bad++;
                $display("FAIL hold_ignore d=%0d got in_ready=%0b wr_en=%0b full=%0b want 0 0 1",
                         d, in_ready[d], bram_wr_en[d], full[d]);
            end
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (in_ready[d] !== 1'b1 || full[d] !== 1'b0 || out_valid[d] !== 1'b0 ||
                out_last[d] !== 1'b0 || bram_wr_en[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state d=%0d got rdy=%0b full=%0b ov=%0b last=%0b we=%0b want 1 0 0 0 0",
                         d, in_ready[d], full[d], out_valid[d], out_last[d], bram_wr_en[d]);
            end
            rst[d] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_natural();
        load_poly(0, 2048, 1'b1, 0, 1'b0);
        drain(0, 2048, 1'b0, 100, 1'b1, 1'b0, -1);
    endtask

    task automatic test_bitrev();
        load_poly(1, 2048, 1'b1, 0, 1'b0);
        drain(1, 2048, 1'b1, 100, 1'b1, 1'b0, -1);
    endtask

    task automatic test_random_stall();
        load_poly(0, 2048, 1'b0, 30, 1'b0);
        drain(0, 2048, 1'b0, 50, 1'b0, 1'b0, -1);
        load_poly(1, 2048, 1'b0, 30, 1'b0);
        drain(1, 2048, 1'b1, 50, 1'b0, 1'b0, -1);
    endtask

    task automatic test_ignored();
        load_poly(0, 2048, 1'b0, 10, 1'b1);
        hold_check(0);
        drain(0, 2048, 1'b0, 70, 1'b0, 1'b1, -1);
    endtask

    task automatic test_reset_mid_drain();
        load_poly(0, 2048, 1'b0, 0, 1'b0);
        drain(0, 2048, 1'b0, 100, 1'b0, 1'b0, 100);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        total++;
        if (out_valid[0] !== 1'b0 || out_last[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
            full[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_drain got ov=%0b last=%0b rdy=%0b full=%0b want 0 0 1 0",
                     out_valid[0], out_last[0], in_ready[0], full[0]);
        end
        load_poly(0, 2048, 1'b0, 20, 1'b0);
        drain(0, 2048, 1'b0, 60, 1'b0, 1'b0, -1);
    endtask

    task automatic test_small();
        load_poly(2, 5, 1'b0, 0, 1'b0);
        drain(2, 5, 1'b0, 100, 1'b1, 1'b0, -1);
        load_poly(2, 5, 1'b0, 40, 1'b0);
        drain(2, 5, 1'b0, 40, 1'b0, 1'b0, -1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b1;
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            start[d]     = 1'b0;
            out_ready[d] = 1'b0;
        end
        test_reset();
        test_natural();
        test_bitrev();
        test_random_stall();
        test_ignored();
        test_reset_mid_drain();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
